// File: rtl/temporizador_regressivo_if.sv
// Control and display bundle between the countdown timer and its driver/decoder.
// Driver raises load/start/pause levels; timer returns registered X/EN/done.
interface temporizador_regressivo_if;
  logic       load;
  logic       start;
  logic       pause;
  logic [6:0] preset;
  logic [6:0] X;
  logic       EN;
  logic       done;

  modport master (
    output load, start, pause, preset,
    input  X, EN, done
  );

  modport slave (
    input  load, start, pause, preset,
    output X, EN, done
  );
endinterface

// File: rtl/temporizador_regressivo.sv
// Countdown timer feeding the two-digit 7-segment decoder: preset load, prescaled countdown,
// pause/resume and blinking at zero. Every action lands one clock after the input edge.
module temporizador_regressivo #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 1,
  parameter int MAXV      = 99
) (
  input  logic                     clk,
  input  logic                     rst_n,
  temporizador_regressivo_if.slave tmr
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam int              BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]      MAXV_C     = 7'(MAXV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    count_q, count_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          load_q, start_q, pause_q;

  logic          ev_load, ev_start, ev_pause;
  logic          tick;
  logic [PW-1:0] presc_next;
  logic [6:0]    preset_sat;

  assign ev_load    = tmr.load  & ~load_q;
  assign ev_start   = tmr.start & ~start_q;
  assign ev_pause   = tmr.pause & ~pause_q;
  assign tick       = (presc_q == TICK_LAST);
  assign presc_next = tick ? '0 : presc_q + PW'(1);
  assign preset_sat = (tmr.preset > MAXV_C) ? MAXV_C : tmr.preset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      en_q    <= 1'b1;
      done_q  <= 1'b0;
      presc_q <= '0;
      blink_q <= '0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      en_q    <= en_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      blink_q <= blink_d;
      load_q  <= tmr.load;
      start_q <= tmr.start;
      pause_q <= tmr.pause;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    en_d    = en_q;
    done_d  = done_q;
    presc_d = presc_q;
    blink_d = blink_q;

    unique case (state_q)
      S_IDLE: begin
        en_d   = 1'b1;
        done_d = 1'b0;
        if (ev_load) begin
          count_d = preset_sat;
          presc_d = '0;
        end else if (ev_start && (count_q != '0)) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end

      S_RUN: begin
        en_d   = 1'b1;
        done_d = 1'b0;
        // A pause that lands on a tick still takes the decrement; reaching zero beats PAUSE.
        if (ev_pause && !tick) begin
          state_d = S_PAUSE;
        end else begin
          presc_d = presc_next;
          if (tick) begin
            if (count_q <= 7'd1) begin
              count_d = '0;
              state_d = S_DONE;
              done_d  = 1'b1;
              blink_d = '0;
            end else begin
              count_d = count_q - 7'd1;
              if (ev_pause) begin
                state_d = S_PAUSE;
              end
            end
          end
        end
      end

      S_PAUSE: begin
        en_d   = 1'b1;
        done_d = 1'b0;
        if (ev_load) begin
          count_d = preset_sat;
          presc_d = '0;
          state_d = S_IDLE;
        end else if (ev_start) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        count_d = '0;
        done_d  = 1'b1;
        presc_d = presc_next;
        if (tick) begin
          if (blink_q == BLINK_LAST) begin
            en_d    = ~en_q;
            blink_d = '0;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
        if (ev_load || ev_start) begin
          count_d = ev_load ? preset_sat : 7'd0;
          state_d = S_IDLE;
          en_d    = 1'b1;
          done_d  = 1'b0;
          presc_d = '0;
          blink_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tmr.X    = count_q;
  assign tmr.EN   = en_q;
  assign tmr.done = done_q;

  a_x_in_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= MAXV_C);
  a_done_state: assert property (@(posedge clk) disable iff (!rst_n) done_q == (state_q == S_DONE));
  a_en_visible: assert property (@(posedge clk) disable iff (!rst_n) (state_q != S_DONE) |-> en_q);
  a_run_nonzero: assert property (@(posedge clk) disable iff (!rst_n) (state_q == S_RUN) |-> (count_q != '0));

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Bench for temporizador_regressivo with TICK_DIV=4, BLINK_DIV=2: vector table, corner sequences,
// then random traffic against a cycles-remaining reference model.
module tb_temporizador_regressivo;
  localparam int TD = 4;
  localparam int BD = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  temporizador_regressivo_if tmr ();

  temporizador_regressivo #(
    .TICK_DIV (TD),
    .BLINK_DIV(BD),
    .MAXV     (99)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tmr  (tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int MI = 0, MR = 1, MP = 2, MD = 3;
  int m_mode, m_x, m_en, m_left, m_bleft;
  bit m_pl, m_ps, m_pp;

  typedef struct {
    logic       l, s, p;
    logic [6:0] pre;
    int         x;
    int         en;
    int         d;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = MI; m_x = 0; m_en = 1; m_left = TD; m_bleft = BD;
    m_pl = 0; m_ps = 0; m_pp = 0;
  endfunction

  // m_left counts clock cycles still to elapse before the next tick.
  function automatic void model_step();
    bit el, es, ep, tk;
    int sat;
    el = tmr.load && !m_pl;
    es = tmr.start && !m_ps;
    ep = tmr.pause && !m_pp;
    m_pl = tmr.load; m_ps = tmr.start; m_pp = tmr.pause;
    sat = (int'(tmr.preset) > 99) ? 99 : int'(tmr.preset);
    tk = (m_left == 1);
    case (m_mode)
      MI: begin
        if (el) begin m_x = sat; m_left = TD; end
        else if (es && m_x != 0) begin m_mode = MR; m_left = TD; end
      end
      MR: begin
        if (ep && !tk) m_mode = MP;
        else begin
          m_left = tk ? TD : m_left - 1;
          if (tk) begin
            m_x = m_x - 1;
            if (m_x == 0) begin m_mode = MD; m_en = 1; m_bleft = BD; end
            else if (ep) m_mode = MP;
          end
        end
      end
      MP: begin
        if (el) begin m_x = sat; m_left = TD; m_mode = MI; end
        else if (es) m_mode = MR;
      end
      default: begin
        m_left = tk ? TD : m_left - 1;
        if (tk) begin
          if (m_bleft == 1) begin m_en = 1 - m_en; m_bleft = BD; end
          else m_bleft = m_bleft - 1;
        end
        if (el || es) begin
          if (el) m_x = sat;
          m_mode = MI; m_en = 1; m_left = TD;
        end
      end
    endcase
  endfunction

  task automatic cyc(input logic l, input logic s, input logic p, input logic [6:0] pre);
    tmr.load = l; tmr.start = s; tmr.pause = p; tmr.preset = pre;
    @(posedge clk);
    model_step();
    #1;
    chk("model_x", int'(tmr.X), m_x);
    chk("model_en", int'(tmr.EN), m_en);
    chk("model_done", int'(tmr.done), (m_mode == MD) ? 1 : 0);
  endtask

  task automatic reset_mid_clock(input string tag);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_x"}, int'(tmr.X), 0);
    chk({tag, "_en"}, int'(tmr.EN), 1);
    chk({tag, "_done"}, int'(tmr.done), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void add(input int n, input int l, input int s, input int p,
                              input int pre, input int x, input int en, input int d);
    vec_t v;
    v.l = l[0]; v.s = s[0]; v.p = p[0]; v.pre = pre[6:0];
    v.x = x; v.en = en; v.d = d;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    tmr.load = 0; tmr.start = 0; tmr.pause = 0; tmr.preset = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("por_x", int'(tmr.X), 0);
    chk("por_en", int'(tmr.EN), 1);
    chk("por_done", int'(tmr.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load saturation, countdown 3->0, no underflow, first blink toggle, start exit.
    add(1, 1,0,0,120, 99,1,0);
    add(1, 0,0,0,5,   99,1,0);
    add(1, 1,0,0,5,    5,1,0);
    add(1, 0,0,0,3,    5,1,0);
    add(1, 1,0,0,3,    3,1,0);
    add(1, 0,0,0,3,    3,1,0);
    add(1, 0,1,0,3,    3,1,0);
    add(3, 0,0,0,3,    3,1,0);
    add(1, 0,0,0,3,    2,1,0);
    add(3, 0,0,0,3,    2,1,0);
    add(1, 0,0,0,3,    1,1,0);
    add(3, 0,0,0,3,    1,1,0);
    add(1, 0,0,0,3,    0,1,1);
    add(7, 0,0,0,3,    0,1,1);
    add(2, 0,0,0,3,    0,0,1);
    add(1, 0,1,0,3,    0,1,0);
    add(1, 0,0,0,3,    0,1,0);
    add(1, 0,1,0,0,    0,1,0);
    add(1, 0,0,0,0,    0,1,0);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].l, vecs[i].s, vecs[i].p, vecs[i].pre);
      chk($sformatf("vec%0d_x", i), int'(tmr.X), vecs[i].x);
      chk($sformatf("vec%0d_en", i), int'(tmr.EN), vecs[i].en);
      chk($sformatf("vec%0d_done", i), int'(tmr.done), vecs[i].d);
    end

    // Reset mid-RUN, start held high from release.
    cyc(1,0,0,9); cyc(0,0,0,9); cyc(0,1,0,9); cyc(0,0,0,9); cyc(0,0,0,9);
    chk("run_before_rst", int'(tmr.X), 9);
    tmr.start = 1'b1;
    reset_mid_clock("rst_run");
    cyc(0,1,0,9);
    chk("start_at_release_x", int'(tmr.X), 0);
    chk("start_at_release_done", int'(tmr.done), 0);
    repeat (6) cyc(0,1,0,9);
    chk("no_tick_after_rst", int'(tmr.X), 0);
    cyc(0,0,0,0);

    // Pause holds the prescaler; resume ticks two clocks later.
    cyc(1,0,0,5); cyc(0,0,0,5);
    cyc(0,1,0,5); cyc(0,0,0,5); cyc(0,0,0,5);
    cyc(0,0,1,5); cyc(0,0,0,5);
    for (int i = 0; i < 20; i++) begin
      cyc(0,0,0,5);
      chk("pause_hold", int'(tmr.X), 5);
    end
    cyc(0,1,0,5);
    chk("resume_c0", int'(tmr.X), 5);
    cyc(0,0,0,5);
    chk("resume_c1", int'(tmr.X), 5);
    cyc(0,0,0,5);
    chk("resume_c2", int'(tmr.X), 4);

    // load+pause together in RUN: pause wins, load ignored.
    cyc(1,0,1,9);
    chk("ld_pause_x", int'(tmr.X), 4);
    chk("ld_pause_done", int'(tmr.done), 0);
    cyc(0,0,0,9);
    repeat (5) cyc(0,0,0,9);
    chk("ld_pause_hold", int'(tmr.X), 4);

    // Pause coincident with the final tick: DONE wins.
    cyc(1,0,0,1); cyc(0,0,0,1);
    chk("paused_load_x", int'(tmr.X), 1);
    cyc(0,1,0,1); cyc(0,0,0,1); cyc(0,0,0,1); cyc(0,0,0,1);
    cyc(0,0,1,1);
    chk("pause_tick_x", int'(tmr.X), 0);
    chk("pause_tick_done", int'(tmr.done), 1);
    chk("pause_tick_en", int'(tmr.EN), 1);

    for (int i = 1; i <= 24; i++) begin
      cyc(0,0,0,0);
      chk($sformatf("blink_en%0d", i), int'(tmr.EN), ((i / 8) % 2 == 0) ? 1 : 0);
    end
    chk("blink_x", int'(tmr.X), 0);
    cyc(0,1,0,0);
    chk("exit_start_en", int'(tmr.EN), 1);
    chk("exit_start_done", int'(tmr.done), 0);
    cyc(0,0,0,0);

    // Leave DONE through load while the display is blanked.
    cyc(1,0,0,2); cyc(0,0,0,2); cyc(0,1,0,2);
    repeat (8) cyc(0,0,0,2);
    chk("reach_done", int'(tmr.done), 1);
    repeat (8) cyc(0,0,0,2);
    chk("blanked", int'(tmr.EN), 0);
    cyc(1,0,0,7);
    chk("exit_load_x", int'(tmr.X), 7);
    chk("exit_load_en", int'(tmr.EN), 1);
    chk("exit_load_done", int'(tmr.done), 0);
    cyc(0,0,0,7);

    for (int i = 0; i < 600; i++) begin
      logic       l, s, p;
      logic [6:0] pre;
      if (i == 300) begin
        reset_mid_clock("rst_rand");
      end
      l = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 7) == 0);
      pre = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 4));
      cyc(l, s, p, pre);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
